// File: rtl/gpio_cfg_pkg.sv
// Shared types and constants for the GPIO configuration write sequencer.
package gpio_cfg_pkg;

  // Transaction phases: grant, address/data setup, strobe high, strobe low.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_GAP    = 2'd3
  } state_e;

  // Word addresses of the four power-up configuration registers.
  localparam logic [11:0] INIT_ADDR_DDR0 = 12'h440;
  localparam logic [11:0] INIT_ADDR_DDR1 = 12'h441;
  localparam logic [11:0] INIT_ADDR_OD0  = 12'h4C0;
  localparam logic [11:0] INIT_ADDR_OD1  = 12'h4C1;

  // Legal range for the strobe high and low times (4-bit cycle counter).
  localparam int CYCLES_MIN = 3;
  localparam int CYCLES_MAX = 15;

  // Map an init word index to its register word address.
  function automatic logic [11:0] init_addr(input logic [1:0] idx);
    case (idx)
      2'd0:    return INIT_ADDR_DDR0;
      2'd1:    return INIT_ADDR_DDR1;
      2'd2:    return INIT_ADDR_OD0;
      default: return INIT_ADDR_OD1;
    endcase
  endfunction

endpackage

// File: rtl/gpio_cfg_init_table.sv
// Combinational lookup of init word index -> register address and data.
module gpio_cfg_init_table
  import gpio_cfg_pkg::*;
#(
  parameter int          AddrWidth = 16,
  parameter int          BusWidth  = 32,
  parameter logic [23:0] DDR_INIT0 = '0,
  parameter logic [23:0] DDR_INIT1 = '0,
  parameter logic [23:0] OD_INIT0  = '0,
  parameter logic [23:0] OD_INIT1  = '0
) (
  input  logic [1:0]           idx_i,
  output logic [AddrWidth-3:0] addr_o,
  output logic [BusWidth-1:0]  data_o
);

  localparam int WordAddrWidth = AddrWidth - 2;

  assign addr_o = WordAddrWidth'(init_addr(idx_i));

  // Select the 24-bit power-up word for this index, zero-extended to the bus.
  always_comb begin
    // NOTE: default first so every path assigns data_o and no latch is inferred.
    data_o = '0;
    case (idx_i)
      2'd0:    data_o = BusWidth'(DDR_INIT0);
      2'd1:    data_o = BusWidth'(DDR_INIT1);
      2'd2:    data_o = BusWidth'(OD_INIT0);
      default: data_o = BusWidth'(OD_INIT1);
    endcase
  end

endmodule

// File: rtl/gpio_cfg_sequencer.sv
// Serialises power-up init writes and host writes onto a slow GPIO
// register-decoder bus with fixed strobe high/low times.
module gpio_cfg_sequencer
  import gpio_cfg_pkg::*;
#(
  parameter int          AddrWidth  = 16,
  parameter int          BusWidth   = 32,
  parameter int          HoldCycles = 4,
  parameter int          GapCycles  = 4,
  parameter logic [23:0] DDR_INIT0  = '0,
  parameter logic [23:0] DDR_INIT1  = '0,
  parameter logic [23:0] OD_INIT0   = '0,
  parameter logic [23:0] OD_INIT1   = '0
) (
  input  logic                 reg_clk,
  input  logic                 reset_reg,
  input  logic                 host_req,
  input  logic [AddrWidth-3:0] host_addr,
  input  logic [BusWidth-1:0]  host_data,
  input  logic                 init_start,
  output logic                 host_ack,
  output logic                 gpio_write,
  output logic [AddrWidth-3:0] gpio_addr,
  output logic [BusWidth-1:0]  gpio_data,
  output logic                 busy,
  output logic                 init_done
);

  if (HoldCycles < CYCLES_MIN || HoldCycles > CYCLES_MAX) begin : g_bad_hold
    $error("gpio_cfg_sequencer: HoldCycles out of range 3..15");
  end
  if (GapCycles < CYCLES_MIN || GapCycles > CYCLES_MAX) begin : g_bad_gap
    $error("gpio_cfg_sequencer: GapCycles out of range 3..15");
  end

  localparam logic [3:0] HoldLast = 4'(HoldCycles - 1);
  localparam logic [3:0] GapLast  = 4'(GapCycles - 1);

  state_e               state_q;
  logic [3:0]           cnt_q;         // shared STROBE/GAP down-counter
  logic [1:0]           word_idx_q;    // init word in flight / next to send
  logic                 init_pend_q;   // init words remain in the current run
  logic                 rerun_q;       // init_start seen, restart at word 0
  logic                 cur_init_q;    // current transaction is an init word
  logic                 init_done_q;
  logic                 host_ack_q;
  logic                 gpio_write_q;
  logic [AddrWidth-3:0] gpio_addr_q;
  logic [BusWidth-1:0]  gpio_data_q;

  logic                 init_want;
  logic [1:0]           tbl_idx;
  logic [AddrWidth-3:0] tbl_addr;
  logic [BusWidth-1:0]  tbl_data;

  // A pending rerun overrides the in-progress index so the run restarts at 0.
  assign init_want = init_pend_q | rerun_q;
  assign tbl_idx   = rerun_q ? 2'd0 : word_idx_q;

  gpio_cfg_init_table #(
    .AddrWidth (AddrWidth),
    .BusWidth  (BusWidth),
    .DDR_INIT0 (DDR_INIT0),
    .DDR_INIT1 (DDR_INIT1),
    .OD_INIT0  (OD_INIT0),
    .OD_INIT1  (OD_INIT1)
  ) u_init_table (
    .idx_i  (tbl_idx),
    .addr_o (tbl_addr),
    .data_o (tbl_data)
  );

  // Sequencer FSM: arbitration, bus timing, init bookkeeping, registered outputs.
  // NOTE: reset is asynchronous so gpio_write drops the instant reset_reg rises.
  always_ff @(posedge reg_clk or posedge reset_reg) begin
    if (reset_reg) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      word_idx_q   <= '0;
      init_pend_q  <= 1'b1;
      rerun_q      <= 1'b0;
      cur_init_q   <= 1'b0;
      init_done_q  <= 1'b0;
      host_ack_q   <= 1'b0;
      gpio_write_q <= 1'b0;
      gpio_addr_q  <= '0;
      gpio_data_q  <= '0;
    end else begin
      // NOTE: non-blocking throughout, so every branch sees start-of-cycle state.
      host_ack_q <= 1'b0;
      if (init_start) rerun_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (init_want) begin
            state_q     <= ST_SETUP;
            gpio_addr_q <= tbl_addr;
            gpio_data_q <= tbl_data;
            cur_init_q  <= 1'b1;
            word_idx_q  <= tbl_idx;
            init_pend_q <= 1'b1;
            rerun_q     <= init_start;
            if (tbl_idx == 2'd0) init_done_q <= 1'b0;
          end else if (host_req) begin
            state_q     <= ST_SETUP;
            gpio_addr_q <= host_addr;
            gpio_data_q <= host_data;
            cur_init_q  <= 1'b0;
          end
        end

        ST_SETUP: begin
          state_q      <= ST_STROBE;
          gpio_write_q <= 1'b1;
          cnt_q        <= HoldLast;
        end

        ST_STROBE: begin
          if (cnt_q == 4'd0) begin
            state_q      <= ST_GAP;
            gpio_write_q <= 1'b0;
            cnt_q        <= GapLast;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end

        ST_GAP: begin
          // Ack lands in the final GAP cycle of a host write only.
          if (cnt_q == 4'd1 && !cur_init_q) host_ack_q <= 1'b1;
          if (cnt_q == 4'd0) begin
            state_q <= ST_IDLE;
            if (cur_init_q) begin
              if (word_idx_q == 2'd3) begin
                init_pend_q <= 1'b0;
                if (!rerun_q && !init_start) init_done_q <= 1'b1;
              end else begin
                word_idx_q <= word_idx_q + 2'd1;
              end
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign host_ack   = host_ack_q;
  assign gpio_write = gpio_write_q;
  assign gpio_addr  = gpio_addr_q;
  assign gpio_data  = gpio_data_q;
  assign init_done  = init_done_q;
  assign busy       = (state_q != ST_IDLE) | init_pend_q | rerun_q;

endmodule

// File: tb/tb_gpio_cfg_sequencer.sv
// Directed bench for gpio_cfg_sequencer with a transaction scoreboard.
module tb_gpio_cfg_sequencer;

  localparam int          AW    = 16;
  localparam int          BW    = 32;
  localparam int          HOLD  = 4;
  localparam int          GAP   = 4;
  localparam logic [23:0] DDR0  = 24'hFFFFFF;
  localparam logic [23:0] DDR1  = 24'h123456;
  localparam logic [23:0] OD0   = 24'h00A5A5;
  localparam logic [23:0] OD1   = 24'h800001;

  typedef struct {
    logic [AW-3:0] addr;
    logic [BW-1:0] data;
    bit            host;
  } txn_t;

  logic          reg_clk = 1'b0;
  logic          reset_reg;
  logic          host_req;
  logic [AW-3:0] host_addr;
  logic [BW-1:0] host_data;
  logic          init_start;
  logic          host_ack;
  logic          gpio_write;
  logic [AW-3:0] gpio_addr;
  logic [BW-1:0] gpio_data;
  logic          busy;
  logic          init_done;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   ack_cnt  = 0;
  txn_t exp_q[$];

  gpio_cfg_sequencer #(
    .AddrWidth  (AW),
    .BusWidth   (BW),
    .HoldCycles (HOLD),
    .GapCycles  (GAP),
    .DDR_INIT0  (DDR0),
    .DDR_INIT1  (DDR1),
    .OD_INIT0   (OD0),
    .OD_INIT1   (OD1)
  ) dut (
    .reg_clk    (reg_clk),
    .reset_reg  (reset_reg),
    .host_req   (host_req),
    .host_addr  (host_addr),
    .host_data  (host_data),
    .init_start (init_start),
    .host_ack   (host_ack),
    .gpio_write (gpio_write),
    .gpio_addr  (gpio_addr),
    .gpio_data  (gpio_data),
    .busy       (busy),
    .init_done  (init_done)
  );

  always #5 reg_clk = ~reg_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_init();
    exp_q.push_back('{14'h440, {8'h0, DDR0}, 1'b0});
    exp_q.push_back('{14'h441, {8'h0, DDR1}, 1'b0});
    exp_q.push_back('{14'h4C0, {8'h0, OD0},  1'b0});
    exp_q.push_back('{14'h4C1, {8'h0, OD1},  1'b0});
  endtask

  // Count rising edges from now until host_ack is seen at a negedge.
  task automatic wait_ack(input int budget, output int n, output bit got);
    n = 0;
    got = 1'b0;
    while (n < budget && !got) begin
      @(posedge reg_clk);
      n++;
      @(negedge reg_clk);
      if (host_ack) got = 1'b1;
    end
  endtask

  task automatic wait_strobe(input logic [AW-3:0] a, input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge reg_clk);
      if (gpio_write && gpio_addr == a) got = 1'b1;
    end
  endtask

  task automatic wait_done(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge reg_clk);
      if (init_done) got = 1'b1;
    end
  endtask

  // Monitor: pop the scoreboard on each strobe, check timing and stability.
  bit   prev_w = 1'b0;
  int   hi_n   = 0;
  int   gap_n  = 0;
  txn_t cur;
  bit   exp_ack;
  always @(negedge reg_clk) begin
    if (reset_reg) begin
      prev_w = 1'b0;
      hi_n   = 0;
      gap_n  = 0;
    end else begin
      exp_ack = 1'b0;
      if (gpio_write && !prev_w) begin
        check("strobe_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          check("strobe_addr", 64'(gpio_addr), 64'(cur.addr));
          check("strobe_data", 64'(gpio_data), 64'(cur.data));
        end
        hi_n  = 1;
        gap_n = 0;
      end else if (gpio_write) begin
        hi_n++;
        check("addr_stable_strobe", 64'(gpio_addr), 64'(cur.addr));
        check("data_stable_strobe", 64'(gpio_data), 64'(cur.data));
      end else if (prev_w) begin
        check("strobe_high_cycles", 64'(hi_n), 64'(HOLD));
        gap_n = 1;
      end else if (gap_n > 0 && gap_n < GAP) begin
        gap_n++;
      end else begin
        gap_n = 0;
      end
      if (gap_n > 0) begin
        check("addr_stable_gap", 64'(gpio_addr), 64'(cur.addr));
        check("data_stable_gap", 64'(gpio_data), 64'(cur.data));
        exp_ack = cur.host && (gap_n == GAP);
      end
      if (host_ack) ack_cnt++;
      if (host_ack || exp_ack) check("host_ack_timing", 64'(host_ack), 64'(exp_ack));
      prev_w = gpio_write;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bit got;
    int acks0;

    reset_reg  = 1'b1;
    host_req   = 1'b0;
    host_addr  = '0;
    host_data  = '0;
    init_start = 1'b0;

    // Reset state.
    repeat (2) @(negedge reg_clk);
    check("rst_gpio_write", 64'(gpio_write), 64'd0);
    check("rst_gpio_addr",  64'(gpio_addr),  64'd0);
    check("rst_gpio_data",  64'(gpio_data),  64'd0);
    check("rst_host_ack",   64'(host_ack),   64'd0);
    check("rst_init_done",  64'(init_done),  64'd0);
    check("rst_busy",       64'(busy),       64'd1);

    // Power-up init sequence after reset release.
    push_init();
    #2 reset_reg = 1'b0;
    @(posedge reg_clk);
    #1 check("init_begins_first_edge", 64'(busy), 64'd1);
    wait_done(200, got);
    check("init_done_after_reset", 64'(got), 64'd1);
    check("init_queue_drained", 64'(exp_q.size()), 64'd0);

    // Host write after init: ack exactly 9 cycles after sampling.
    @(negedge reg_clk);
    host_req  = 1'b1;
    host_addr = 14'h441;
    host_data = 32'h0000_03FF;
    exp_q.push_back('{14'h441, 32'h0000_03FF, 1'b1});
    wait_ack(100, n, got);
    host_req = 1'b0;
    check("host_ack_seen", 64'(got), 64'd1);
    check("host_ack_latency", 64'(n), 64'(1 + HOLD + GAP));

    // Host request during init word 1 waits for words 2 and 3.
    @(negedge reg_clk);
    push_init();
    init_start = 1'b1;
    @(negedge reg_clk);
    init_start = 1'b0;
    wait_strobe(14'h441, 100, got);
    check("reach_init_word1", 64'(got), 64'd1);
    acks0     = ack_cnt;
    host_req  = 1'b1;
    host_addr = 14'h123;
    host_data = 32'hDEAD_BEEF;
    exp_q.push_back('{14'h123, 32'hDEAD_BEEF, 1'b1});
    wait_ack(200, n, got);
    host_req = 1'b0;
    check("queued_host_ack_seen", 64'(got), 64'd1);
    check("init_done_before_host", 64'(init_done), 64'd1);
    repeat (20) @(negedge reg_clk);
    check("single_host_ack", 64'(ack_cnt - acks0), 64'd1);
    check("queue_after_queued_host", 64'(exp_q.size()), 64'd0);

    // init_start during a host strobe: host completes, then full init.
    @(negedge reg_clk);
    host_req  = 1'b1;
    host_addr = 14'h2AA;
    host_data = 32'h5555_AAAA;
    exp_q.push_back('{14'h2AA, 32'h5555_AAAA, 1'b1});
    wait_strobe(14'h2AA, 50, got);
    check("reach_host_strobe", 64'(got), 64'd1);
    push_init();
    init_start = 1'b1;
    @(negedge reg_clk);
    init_start = 1'b0;
    wait_ack(100, n, got);
    host_req = 1'b0;
    check("host_ack_before_rerun", 64'(got), 64'd1);
    wait_strobe(14'h440, 50, got);
    check("rerun_starts", 64'(got), 64'd1);
    check("init_done_low_in_rerun", 64'(init_done), 64'd0);
    wait_strobe(14'h4C1, 100, got);
    check("init_done_low_last_word", 64'(init_done), 64'd0);
    wait_done(100, got);
    check("init_done_after_rerun", 64'(got), 64'd1);
    check("queue_after_rerun", 64'(exp_q.size()), 64'd0);

    // Host request dropped while init runs: no strobe, no ack.
    @(negedge reg_clk);
    acks0 = ack_cnt;
    push_init();
    init_start = 1'b1;
    @(negedge reg_clk);
    init_start = 1'b0;
    wait_strobe(14'h440, 50, got);
    host_req  = 1'b1;
    host_addr = 14'h0F0;
    host_data = 32'h1111_2222;
    wait_strobe(14'h441, 100, got);
    host_req = 1'b0;
    wait_done(200, got);
    check("init_done_after_drop", 64'(got), 64'd1);
    repeat (20) @(negedge reg_clk);
    check("dropped_req_no_ack", 64'(ack_cnt - acks0), 64'd0);
    check("dropped_req_no_write", 64'(exp_q.size()), 64'd0);
    check("idle_not_busy", 64'(busy), 64'd0);

    // Reset in the second strobe cycle drops gpio_write at once.
    @(negedge reg_clk);
    acks0     = ack_cnt;
    host_req  = 1'b1;
    host_addr = 14'h3C3;
    host_data = 32'hCAFE_F00D;
    exp_q.push_back('{14'h3C3, 32'hCAFE_F00D, 1'b1});
    wait_strobe(14'h3C3, 50, got);
    check("reach_strobe_for_reset", 64'(got), 64'd1);
    @(posedge reg_clk);
    #2 reset_reg = 1'b1;
    #1;
    check("reset_drops_write", 64'(gpio_write), 64'd0);
    check("reset_clears_addr", 64'(gpio_addr),  64'd0);
    check("reset_clears_done", 64'(init_done),  64'd0);
    host_req = 1'b0;
    @(negedge reg_clk);
    exp_q.delete();
    push_init();
    #2 reset_reg = 1'b0;
    wait_done(200, got);
    check("init_done_after_midreset", 64'(got), 64'd1);
    check("queue_after_midreset", 64'(exp_q.size()), 64'd0);
    check("no_ack_for_aborted_write", 64'(ack_cnt - acks0), 64'd0);

    repeat (5) @(negedge reg_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
